// File: rtl/pipeline_hazard_controller.sv
// RAW-hazard stall and taken-branch flush/redirect sequencer for a 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to build the stall/flush statistics counters.
module pipeline_hazard_controller #(
    parameter bit          WB_BYPASS   = 1'b1,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_dst,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic        wb_valid,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dst,
    input  logic        mem_redirect,
    input  logic [31:0] mem_redirect_pc,
    output logic        pc_write,
    output logic        pc_sel_redirect,
    output logic [31:0] redirect_pc,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        id_ex_bubble,
    output logic        stall_active,
    output logic        hazard_error,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_REDIRECT} state_t;

    state_t      r_state;
    logic [31:0] r_redirect_pc;
    logic [7:0]  r_stall_cnt;
    logic        r_hazard_error;

    logic        w_hz;
    logic        w_rd;
    logic        w_active;
    logic        w_take_rd;
    logic        w_stall;
    logic        w_limit_hit;
    logic [8:0]  w_cnt_plus;

    // $zero is never a real dependency, whatever an older instruction claims to write.
    function automatic logic src_hit(input logic [4:0] src);
        logic hit;
        hit = ex_valid & ex_reg_write & (ex_dst == src);
        hit = hit | (mem_valid & mem_reg_write & (mem_dst == src));
        hit = hit | (!WB_BYPASS & wb_valid & wb_reg_write & (wb_dst == src));
        return (src != 5'd0) & hit;
    endfunction

    always_comb begin
        w_hz        = id_valid & ((id_uses_rs & src_hit(id_rs)) | (id_uses_rt & src_hit(id_rt)));
        w_rd        = mem_redirect & mem_valid;
        w_active    = !reset && (r_state != S_REDIRECT);
        w_take_rd   = w_active & w_rd;
        w_stall     = w_active & ~w_rd & w_hz;
        w_cnt_plus  = {1'b0, r_stall_cnt} + 9'd1;
        w_limit_hit = w_stall && (w_cnt_plus >= 9'(STALL_LIMIT));
    end

    always_comb begin
        pc_write        = 1'b0;
        pc_sel_redirect = 1'b0;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        id_ex_bubble    = 1'b0;
        stall_active    = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (r_state == S_REDIRECT) begin
            pc_sel_redirect = 1'b1;
            pc_write        = 1'b1;
            if_id_write     = 1'b1;
            if_id_flush     = 1'b1;
        end else if (w_rd) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_hz) begin
            id_ex_bubble = 1'b1;
            stall_active = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_redirect_pc  <= 32'd0;
            r_stall_cnt    <= 8'd0;
            r_hazard_error <= 1'b0;
        end else if (r_state == S_REDIRECT) begin
            r_state <= S_RUN;
        end else if (w_rd) begin
            r_state       <= S_REDIRECT;
            r_redirect_pc <= mem_redirect_pc;
            r_stall_cnt   <= 8'd0;
        end else if (w_hz) begin
            r_state     <= S_STALL;
            r_stall_cnt <= (r_stall_cnt == 8'hFF) ? 8'hFF : w_cnt_plus[7:0];
            if (w_limit_hit)
                r_hazard_error <= 1'b1;
        end else begin
            r_state     <= S_RUN;
            r_stall_cnt <= 8'd0;
        end
    end

    assign redirect_pc  = r_redirect_pc;
    // The limit-reaching stall cycle itself already reports the error.
    assign hazard_error = r_hazard_error | w_limit_hit;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (w_stall && r_stall_count != 16'hFFFF)
                r_stall_count <= r_stall_count + 16'd1;
            if (w_take_rd && r_flush_count != 16'hFFFF)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a behavioural model queues expected
// outputs per driven cycle, and the negedge checker pops and compares them.
module tb_pipeline_hazard_controller;

    localparam bit WB_BYPASS   = 1'b1;
    localparam int STALL_LIMIT = 15;
`ifdef HAZARD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk, reset;
    logic        id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]  id_rs, id_rt;
    logic        ex_valid, ex_reg_write, mem_valid, mem_reg_write, wb_valid, wb_reg_write;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic        mem_redirect;
    logic [31:0] mem_redirect_pc;
    logic        pc_write, pc_sel_redirect, if_id_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, stall_active, hazard_error;
    logic [31:0] redirect_pc;
    logic [15:0] stall_count, flush_count;

    pipeline_hazard_controller #(.WB_BYPASS(WB_BYPASS), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .mem_redirect(mem_redirect), .mem_redirect_pc(mem_redirect_pc),
        .pc_write(pc_write), .pc_sel_redirect(pc_sel_redirect), .redirect_pc(redirect_pc),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .id_ex_bubble(id_ex_bubble), .stall_active(stall_active),
        .hazard_error(hazard_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        logic        pcw, sel, ifw, ifwCare, f1, f2, f3, bub, stall, err;
        logic [31:0] rpc;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t        sb[$];
    exp_t        expNow;
    int          checks = 0;
    int          failures = 0;
    int          mState = 0;
    int          mCnt = 0;
    logic [31:0] mRpc = 0;
    logic        mErr = 0;
    int          mSc = 0;
    int          mFc = 0;
    bit          mKnown = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic modelHit(input logic [4:0] src);
        if (src == 5'd0) return 1'b0;
        if (ex_valid && ex_reg_write && ex_dst == src) return 1'b1;
        if (mem_valid && mem_reg_write && mem_dst == src) return 1'b1;
        if (!WB_BYPASS && wb_valid && wb_reg_write && wb_dst == src) return 1'b1;
        return 1'b0;
    endfunction

    // Computes this cycle's expected outputs from the model state, queues them, then advances the model.
    task automatic applyStimulus();
        exp_t e;
        logic hz, rd;
        e = '{default: '0};
        hz = id_valid && ((id_uses_rs && modelHit(id_rs)) || (id_uses_rt && modelHit(id_rt)));
        rd = mem_redirect && mem_valid;
        e.rpc = mRpc; e.err = mErr; e.sc = 16'(mSc); e.fc = 16'(mFc);
        if (reset) begin
            e.f1 = 1; e.f2 = 1; e.f3 = 1; e.ifwCare = 1;
            mState = 0; mRpc = 0; mCnt = 0; mErr = 0; mSc = 0; mFc = 0;
        end else if (mState == 2) begin
            e.sel = 1; e.pcw = 1; e.f1 = 1;
            mState = 0;
        end else if (rd) begin
            e.f1 = 1; e.f2 = 1; e.f3 = 1;
            mRpc = mem_redirect_pc; mCnt = 0; mState = 2;
            if (STATS_EN && mFc < 65535) mFc++;
        end else if (hz) begin
            e.bub = 1; e.stall = 1; e.ifwCare = 1;
            if (mCnt + 1 >= STALL_LIMIT) begin e.err = 1; mErr = 1; end
            if (mCnt < 255) mCnt++;
            mState = 1;
            if (STATS_EN && mSc < 65535) mSc++;
        end else begin
            e.pcw = 1; e.ifw = 1; e.ifwCare = 1;
            mCnt = 0; mState = 0;
        end
        if (mKnown) sb.push_back(e);
        if (reset) mKnown = 1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expNow = sb.pop_front();
            checkOutput("pc_write", pc_write, expNow.pcw);
            checkOutput("pc_sel_redirect", pc_sel_redirect, expNow.sel);
            checkOutput("redirect_pc", redirect_pc, expNow.rpc);
            if (expNow.ifwCare) checkOutput("if_id_write", if_id_write, expNow.ifw);
            checkOutput("if_id_flush", if_id_flush, expNow.f1);
            checkOutput("id_ex_flush", id_ex_flush, expNow.f2);
            checkOutput("ex_mem_flush", ex_mem_flush, expNow.f3);
            checkOutput("id_ex_bubble", id_ex_bubble, expNow.bub);
            checkOutput("stall_active", stall_active, expNow.stall);
            checkOutput("hazard_error", hazard_error, expNow.err);
            checkOutput("stall_count", stall_count, expNow.sc);
            checkOutput("flush_count", flush_count, expNow.fc);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_valid = 0; ex_reg_write = 0; ex_dst = 0;
        mem_valid = 0; mem_reg_write = 0; mem_dst = 0;
        wb_valid = 0; wb_reg_write = 0; wb_dst = 0;
        mem_redirect = 0; mem_redirect_pc = 0;
    endtask

    task automatic setRawOnEx(input logic [4:0] r);
        id_valid = 1; id_rs = r; id_uses_rs = 1;
        ex_valid = 1; ex_reg_write = 1; ex_dst = r;
    endtask

    task automatic setRedirect(input logic [31:0] pc);
        mem_valid = 1; mem_redirect = 1; mem_redirect_pc = pc;
    endtask

    initial begin
        clearInputs();
        reset = 1;
        nextCycle(); applyStimulus();
        nextCycle(); applyStimulus();
        nextCycle(); reset = 0; applyStimulus();
        nextCycle(); applyStimulus();

        // EX producer of $t0 walks down the pipe while ID keeps reading $t0.
        nextCycle(); setRawOnEx(5'd8); applyStimulus();
        @(negedge clk); checkOutput("ex_stall_pcw", pc_write, 0); checkOutput("ex_stall_bub", id_ex_bubble, 1);
        nextCycle(); ex_valid = 0; mem_valid = 1; mem_reg_write = 1; mem_dst = 8; applyStimulus();
        @(negedge clk); checkOutput("mem_stall_pcw", pc_write, 0); checkOutput("mem_stall_bub", id_ex_bubble, 1);
        nextCycle(); mem_valid = 0; wb_valid = 1; wb_reg_write = 1; wb_dst = 8; applyStimulus();
        @(negedge clk); checkOutput("wb_bypass_pcw", pc_write, 1); checkOutput("stall_count_2", stall_count, STATS_EN ? 2 : 0);

        // $zero dependencies never stall.
        for (int i = 0; i < 3; i++) begin
            nextCycle(); clearInputs(); setRawOnEx(5'd0); id_uses_rt = 1;
            mem_valid = 1; mem_reg_write = 1; applyStimulus();
            @(negedge clk); checkOutput("zero_reg_pcw", pc_write, 1);
        end

        nextCycle(); clearInputs(); setRedirect(32'h0040_0020); applyStimulus();
        @(negedge clk); checkOutput("rd_flush3", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
        nextCycle(); clearInputs(); applyStimulus();
        @(negedge clk); checkOutput("rd_sel", pc_sel_redirect, 1); checkOutput("rd_pc", redirect_pc, 32'h0040_0020);
        nextCycle(); applyStimulus();
        @(negedge clk); checkOutput("rd_back_run", pc_sel_redirect, 0);

        // Redirect and hazard together: redirect wins.
        nextCycle(); setRawOnEx(5'd9); setRedirect(32'h0040_0100); applyStimulus();
        @(negedge clk); checkOutput("rdhz_bubble", id_ex_bubble, 0); checkOutput("rdhz_flush", ex_mem_flush, 1);
        nextCycle(); clearInputs(); applyStimulus();
        @(negedge clk); checkOutput("rdhz_fc", flush_count, STATS_EN ? 2 : 0); checkOutput("rdhz_sc", stall_count, STATS_EN ? 2 : 0);
        nextCycle(); applyStimulus();

        // Watchdog.
        for (int i = 1; i <= STALL_LIMIT; i++) begin
            nextCycle(); setRawOnEx(5'd12); applyStimulus();
            @(negedge clk); checkOutput($sformatf("wd_cycle%0d", i), hazard_error, (i >= STALL_LIMIT) ? 1 : 0);
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle(); clearInputs(); applyStimulus();
            @(negedge clk); checkOutput("wd_sticky", hazard_error, 1);
        end
        nextCycle(); reset = 1; applyStimulus();
        nextCycle(); reset = 0; applyStimulus();
        @(negedge clk); checkOutput("wd_cleared", hazard_error, 0);

        // Reset arriving in REDIRECT.
        nextCycle(); setRedirect(32'h1234_5678); applyStimulus();
        nextCycle(); clearInputs(); reset = 1; applyStimulus();
        @(negedge clk); checkOutput("rst_rd_sel", pc_sel_redirect, 0); checkOutput("rst_rd_flush", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
        nextCycle(); reset = 0; applyStimulus();
        @(negedge clk); checkOutput("rst_rd_pc", redirect_pc, 0); checkOutput("rst_rd_sel2", pc_sel_redirect, 0);

        for (int i = 0; i < 300; i++) begin
            nextCycle();
            reset = ($urandom_range(0, 49) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
            ex_valid = 1'($urandom_range(0, 1)); ex_reg_write = 1'($urandom_range(0, 1)); ex_dst = 5'($urandom_range(0, 3));
            mem_valid = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1)); mem_dst = 5'($urandom_range(0, 3));
            wb_valid = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1)); wb_dst = 5'($urandom_range(0, 3));
            mem_redirect = ($urandom_range(0, 5) == 0); mem_redirect_pc = $urandom;
            applyStimulus();
        end

        nextCycle(); clearInputs(); reset = 0;
        @(negedge clk);
        checkOutput("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It detects read-after-write hazards between the instruction in ID and older in-flight instructions, and stalls the front end until the hazard clears. It turns a taken branch or jump resolved in MEM into a two-cycle flush/redirect sequence. It sits beside the pipeline registers and drives their write-enable and flush inputs and the PC source select.

## Interface
- `WB_BYPASS`, 1: 1 = register file writes in the first half-cycle, so a WB-stage match is not a hazard; 0 = a WB match stalls.
- `STALL_LIMIT`, 15: consecutive stall cycles that set `hazard_error`; range 1..255.
- `clk` in 1: pipeline clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in 5 each: ID source register numbers.
- `id_uses_rs`, `id_uses_rt` in 1 each: the source is actually read.
- `ex_valid`, `ex_reg_write` in 1 each; `ex_dst` in 5: EX destination.
- `mem_valid`, `mem_reg_write` in 1 each; `mem_dst` in 5: MEM destination.
- `wb_valid`, `wb_reg_write` in 1 each; `wb_dst` in 5: WB destination.
- `mem_redirect` in 1: the MEM instruction is a taken branch or jump.
- `mem_redirect_pc` in 32: target address for `mem_redirect`.
- `pc_write` out 1: PC register enable.
- `pc_sel_redirect` out 1: PC loads `redirect_pc` instead of PC+4.
- `redirect_pc` out 32: registered redirect target.
- `if_id_write` out 1: IF/ID enable.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1 each: load a bubble (valid=0, controls 0).
- `id_ex_bubble` out 1: ID/EX loads a bubble because of a stall.
- `stall_active` out 1: a RAW stall is in effect this cycle.
- `hazard_error` out 1: sticky watchdog flag.
- `stall_count`, `flush_count` out 16 each: statistics (see Configuration).

## Operation
- Hazard term `hz`: `id_valid` AND, for rs (if `id_uses_rs`) or rt (if `id_uses_rt`), a source register ≠ 0 that equals:
  - `ex_dst` with `ex_valid & ex_reg_write`, or
  - `mem_dst` with `mem_valid & mem_reg_write`, or
  - `wb_dst` with `wb_valid & wb_reg_write`, only when `WB_BYPASS`=0.
- Redirect term `rd` = `mem_redirect & mem_valid`.
- States: RUN, STALL, REDIRECT. Outputs are Mealy, decoded from the state plus `hz`/`rd`.
- RUN or STALL with `rd`:
  - Outputs: `if_id_flush`, `id_ex_flush`, `ex_mem_flush` = 1; `pc_write` = 0.
  - `redirect_pc` <= `mem_redirect_pc`; stall counter cleared; next state REDIRECT.
  - `rd` has priority over `hz`.
- RUN or STALL with `hz` and no `rd`:
  - Outputs: `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, `stall_active` = 1.
  - Stall counter +1; next state STALL.
- RUN or STALL with neither:
  - Outputs: `pc_write` = 1, `if_id_write` = 1; all flush and bubble outputs 0.
  - Stall counter cleared; next state RUN.
- REDIRECT:
  - Outputs: `pc_sel_redirect` = 1, `pc_write` = 1, `if_id_flush` = 1 (the word fetched from the stale PC is killed).
  - `hz` and `rd` are ignored, since ID, EX and MEM hold bubbles; next state RUN.
- Watchdog: when the stall counter reaches `STALL_LIMIT`, `hazard_error` is set and stays 1 until reset. Stalling continues regardless.
- Stall counter is 8 bits and saturates at 255.

## Timing
- Reset (sampled high at a `clk` edge):
  - Registers: state RUN, `redirect_pc` = 0, stall counter = 0, `hazard_error` = 0, statistics = 0.
  - While `reset` is high, outputs are forced: `pc_write` = 0, `if_id_write` = 0, all three flushes = 1, `id_ex_bubble` = 0, `pc_sel_redirect` = 0, `stall_active` = 0.
  - Reset during REDIRECT abandons the redirect.
- Stall latency: 0 cycles. The enables drop in the same cycle `hz` rises and recover in the cycle `hz` falls.
- Redirect: the flush is in cycle t (`rd`). The PC loads `redirect_pc` at the end of t+1. The first target instruction is in IF during t+2.
- Redirect penalty is 4 bubbles: 3 flushed in t, 1 IF/ID flush in t+1.
- EX-stage producer without WB bypass: 3 stall cycles. With WB bypass: 2.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_count` increments on every cycle with `stall_active` = 1.
  - `flush_count` increments on every cycle with `rd` accepted.
  - Both are 16-bit and saturate at 0xFFFF.
- `HAZARD_STATS_EN` undefined: both outputs are tied to 0 and no counter registers are synthesized.

## Test plan
- `add $t0` in EX, ID reads `$t0`, `WB_BYPASS`=1 -> exactly 2 cycles of `pc_write` = 0 and `id_ex_bubble` = 1, then `pc_write` = 1; `stall_count` = 2.
- ID reads `$zero` while EX writes `$zero` -> no stall; `pc_write` = 1 every cycle.
- `rd` with `mem_redirect_pc` = 0x0040_0020 -> cycle t: three flushes = 1; t+1: `pc_sel_redirect` = 1, `redirect_pc` = 0x0040_0020, `if_id_flush` = 1; t+2: RUN.
- `rd` and `hz` in the same cycle -> flushes win, `id_ex_bubble` = 0, `flush_count` +1, `stall_count` unchanged.
- `hz` held for 15 cycles (`STALL_LIMIT` = 15) -> `hazard_error` = 1 on the 15th stall cycle and stays 1 after `hz` drops, until reset.
- `reset` asserted in REDIRECT -> next cycle is RUN, `redirect_pc` = 0, `pc_sel_redirect` = 0; flushes = 1 while `reset` is high.
